// File: rtl/pdua_int_ctrl.sv
// PDUA memory-mapped interrupt controller: edge-detected pending bits, mask, cause and GIE in a 4-byte window.
// Optional macro PDUA_INTC_SYNC_EN adds a 2-flop input synchronizer ahead of the edge-detect stage.
module pdua_int_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_SRC    = 4,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 'hFC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic                  wr_rdn,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    input  logic [NUM_SRC-1:0]    irq_in,
    output logic                  int_out
);

    logic                  hit;
    logic [1:0]            offset;
    logic                  wr_en;
    logic [NUM_SRC-1:0]    samp;
    logic [NUM_SRC-1:0]    prev;
    logic [NUM_SRC-1:0]    rise;
    logic [NUM_SRC-1:0]    pend;
    logic [NUM_SRC-1:0]    mask;
    logic [NUM_SRC-1:0]    pend_en;
    logic [NUM_SRC-1:0]    w1c;
    logic [NUM_SRC-1:0]    pend_next;
    logic                  gie;
    logic [DATA_WIDTH-1:0] cause;
    logic [DATA_WIDTH-1:0] rd_next;
    logic                  unused_w_data;

    assign hit    = (addr[DATA_WIDTH-1:2] == BASE_ADDR[DATA_WIDTH-1:2]);
    assign offset = addr[1:0];
    assign wr_en  = hit & wr_rdn;

    // Upper write-data bits have no destination in any register.
    assign unused_w_data = ^w_data;

`ifdef PDUA_INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            samp  <= '0;
        end else begin
            sync1 <= irq_in;
            samp  <= sync1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= '0;
        end else begin
            samp <= irq_in;
        end
    end
`endif

    // prev clears on reset, so a line already high at release is seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= samp;
        end
    end

    assign rise    = samp & ~prev;
    assign pend_en = pend & mask;

    always_comb begin
        w1c = '0;
        if (wr_en && offset == 2'd0) begin
            w1c = w_data[NUM_SRC-1:0];
        end
    end

    // A new edge wins over a simultaneous write-1-to-clear of the same bit.
    assign pend_next = (pend & ~w1c) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            mask <= '0;
            gie  <= 1'b0;
        end else begin
            pend <= pend_next;
            if (wr_en && offset == 2'd1) begin
                mask <= w_data[NUM_SRC-1:0];
            end
            if (wr_en && offset == 2'd3) begin
                gie <= w_data[0];
            end
        end
    end

    // Fixed priority: scanning downward leaves the lowest pending-enabled index.
    always_comb begin
        cause = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                cause[7]   = 1'b1;
                cause[2:0] = i[2:0];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        if (hit && !wr_rdn) begin
            case (offset)
                2'd0:    rd_next[NUM_SRC-1:0] = pend;
                2'd1:    rd_next[NUM_SRC-1:0] = mask;
                2'd2:    rd_next = cause;
                default: rd_next[0] = gie;
            endcase
        end
    end

    // int_out follows the registered PEND/MASK/GIE, hence one cycle behind them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            int_out <= 1'b0;
        end else begin
            r_data  <= rd_next;
            int_out <= gie & (|pend_en);
        end
    end

endmodule

// File: tb/tb_pdua_int_ctrl.sv
// Directed self-checking bench for pdua_int_ctrl; expected values are hand-computed per scenario.
module tb_pdua_int_ctrl;

`ifdef PDUA_INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [7:0] A_PEND  = 8'hFC;
    localparam logic [7:0] A_MASK  = 8'hFD;
    localparam logic [7:0] A_CAUSE = 8'hFE;
    localparam logic [7:0] A_CTRL  = 8'hFF;
    localparam logic [7:0] A_IDLE  = 8'h10;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       wr_rdn;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic [3:0] irq_in;
    logic       int_out;

    int checks;
    int errors;
    logic [7:0] rd;

    pdua_int_ctrl #(
        .DATA_WIDTH(8),
        .NUM_SRC   (4),
        .BASE_ADDR (8'hFC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wr_rdn (wr_rdn),
        .w_data (w_data),
        .r_data (r_data),
        .irq_in (irq_in),
        .int_out(int_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        wr_rdn = 1'b1;
        w_data = d;
        tick();
        addr   = A_IDLE;
        wr_rdn = 1'b0;
        w_data = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        addr   = a;
        wr_rdn = 1'b0;
        tick();
        d      = r_data;
        addr   = A_IDLE;
    endtask

    task automatic test_reset();
        logic [7:0] a;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_int_out got %b exp 0", int_out);
        end
        checks++;
        if (r_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_r_data got %h exp 00", r_data);
        end
        for (int i = 0; i < 4; i++) begin
            a = 8'hFC + i[7:0];
            bus_read(a, rd);
            checks++;
            if (rd !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr %h got %h exp 00", a, rd);
            end
        end
        bus_read(A_IDLE, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_read_miss got %h exp 00", rd);
        end
    endtask

    task automatic test_regs();
        bus_write(A_MASK, 8'hFF);
        bus_read(A_MASK, rd);
        checks++;
        if (rd !== 8'h0F) begin
            errors++;
            $display("FAIL mask_width got %h exp 0F", rd);
        end
        bus_write(A_CTRL, 8'hFE);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL ctrl_bit0_only got %h exp 00", rd);
        end
        bus_write(8'h7D, 8'h00);
        bus_write(A_CAUSE, 8'hFF);
        bus_read(A_MASK, rd);
        checks++;
        if (rd !== 8'h0F) begin
            errors++;
            $display("FAIL miss_write_ignored got %h exp 0F", rd);
        end
        bus_read(A_CAUSE, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL cause_ro got %h exp 00", rd);
        end
        bus_read(A_IDLE, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL miss_read_zero got %h exp 00", rd);
        end
        bus_write(A_MASK, 8'h00);
    endtask

    task automatic test_basic();
        bus_write(A_MASK, 8'h04);
        bus_write(A_CTRL, 8'h01);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        repeat (LAT) tick();
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_int_early got %b exp 0", int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_int_latency got %b exp 1", int_out);
        end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h04) begin
            errors++;
            $display("FAIL basic_pend got %h exp 04", rd);
        end
        bus_read(A_CAUSE, rd);
        checks++;
        if (rd !== 8'h82) begin
            errors++;
            $display("FAIL basic_cause got %h exp 82", rd);
        end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h04) begin
            errors++;
            $display("FAIL read_no_clear got %h exp 04", rd);
        end
        bus_write(A_PEND, 8'h04);
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL w1c_int_lag got %b exp 1", int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL w1c_int_drop got %b exp 0", int_out);
        end
    endtask

    task automatic test_masked();
        bus_write(A_MASK, 8'h00);
        irq_in[1] = 1'b1;
        repeat (LAT + 3) tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL masked_pend got %h exp 02", rd);
        end
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL masked_int got %b exp 0", int_out);
        end
        bus_write(A_MASK, 8'h02);
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL unmask_lag got %b exp 0", int_out);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL unmask_int got %b exp 1", int_out);
        end
        bus_write(A_CTRL, 8'h00);
        tick();
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL gie_off_int got %b exp 0", int_out);
        end
        irq_in[1] = 1'b0;
        bus_write(A_PEND, 8'h02);
    endtask

    task automatic test_priority();
        bus_write(A_MASK, 8'h0F);
        bus_write(A_CTRL, 8'h01);
        irq_in[3] = 1'b1;
        irq_in[1] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        irq_in[1] = 1'b0;
        repeat (LAT + 2) tick();
        bus_read(A_CAUSE, rd);
        checks++;
        if (rd !== 8'h81) begin
            errors++;
            $display("FAIL prio_cause_1 got %h exp 81", rd);
        end
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL prio_int got %b exp 1", int_out);
        end
        bus_write(A_PEND, 8'h02);
        bus_read(A_CAUSE, rd);
        checks++;
        if (rd !== 8'h83) begin
            errors++;
            $display("FAIL prio_cause_3 got %h exp 83", rd);
        end
        bus_write(A_PEND, 8'h08);
        bus_read(A_CAUSE, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL prio_cause_none got %h exp 00", rd);
        end
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL prio_int_clear got %b exp 0", int_out);
        end
    endtask

    task automatic test_collision();
        irq_in[0] = 1'b1;
        irq_in[2] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        irq_in[2] = 1'b0;
        repeat (LAT + 2) tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h05) begin
            errors++;
            $display("FAIL coll_setup got %h exp 05", rd);
        end
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        repeat (LAT - 1) tick();
        bus_write(A_PEND, 8'h05);
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL coll_int got %b exp 1", int_out);
        end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("FAIL coll_pend got %h exp 01", rd);
        end
    endtask

    task automatic test_reset_mid();
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        repeat (LAT + 2) tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h05 || int_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup got pend %h int %b exp 05 1", rd, int_out);
        end
        irq_in[0] = 1'b1;
        addr      = A_PEND;
        rst       = 1'b1;
        tick();
        rst  = 1'b0;
        addr = A_IDLE;
        checks++;
        if (int_out !== 1'b0 || r_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_out got int %b r_data %h exp 0 00", int_out, r_data);
        end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL midrst_pend got %h exp 00", rd);
        end
        bus_read(A_MASK, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL midrst_mask got %h exp 00", rd);
        end
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL midrst_ctrl got %h exp 00", rd);
        end
        repeat (LAT + 2) tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("FAIL level_edge got %h exp 01", rd);
        end
        bus_write(A_PEND, 8'h01);
        repeat (4) tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL level_once got %h exp 00", rd);
        end
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL level_int got %b exp 0", int_out);
        end
        irq_in[0] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        addr   = A_IDLE;
        wr_rdn = 1'b0;
        w_data = 8'h00;
        irq_in = 4'h0;
        test_reset();
        test_regs();
        test_basic();
        test_masked();
        test_priority();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
